scope_capture_buffer: RTL
=========================

# scope_capture_buffer

Multi-channel, triggered waveform capture buffer for the audio-scope display path. It sits between the sampled audio source and the LCD scan-out. It decimates incoming samples and captures a pre/post-trigger window into one of two banks. The completed bank is swapped to the display side on a frame-sync edge, so scan-out never sees a partially written capture. It generalises the fixed two-bank, free-running wave buffer to N channels, configurable width and depth, level triggering with pre-trigger, and single-shot mode.

## Interface
- CH, 2, number of channels captured in parallel
- W, 16, sample width (two's complement)
- DEPTH, 1024, samples per channel per bank; power of two, at least 4
- PRE, 256, pre-trigger samples; 0 <= PRE < DEPTH
- AW, $clog2(DEPTH), address width (derived)
- CLK  in  1  single clock for all logic and both memory ports
- RESET  in  1  asynchronous, active-high reset
- SAMPLE_EN  in  1  one-cycle strobe; WAVE is valid in this cycle
- WAVE  in  CH*W  channel c occupies bits [c*W +: W]
- SCAL  in  3  decimation: store one of every SCAL+1 strobes
- RUN  in  1  level; high enables capture
- TRIG_MODE  in  2  0 free-run, 1 rising edge, 2 falling edge, 3 single-shot rising
- TRIG_CH  in  max(1,$clog2(CH))  channel compared against TRIG_LEVEL
- TRIG_LEVEL  in  W  signed threshold
- FRAME_SYNC  in  1  display vertical sync; edge-detected internally
- RD_ADDR  in  AW  display read index; 0 = oldest sample of the capture
- RD_DATA  out  CH*W  display-bank data, registered
- BANK  out  1  bank currently being displayed
- ARMED  out  1  high in state ARM
- TRIG_SEEN  out  1  pulses one cycle when the trigger is accepted
- CAPT_DONE  out  1  high in state DONE

## Operation
- Decimator: counts SAMPLE_EN pulses from 0 to SCAL, then wraps. A stored sample (strobe) occurs on a pulse while the count is 0. A SCAL change takes effect at the next wrap.
- Writes go to bank ~BANK at address wp, as a CH*W-wide word. wp increments mod DEPTH on each stored sample.
- States:
  - IDLE: no writes. On RUN high (for single-shot, a RUN rising edge), set wp=0 and n=0, then go to PRE.
  - PRE: write stored samples and count n. When n reaches PRE, go to ARM. If PRE=0, go to ARM immediately.
  - ARM: write stored samples.
    - Rising trigger: prev < TRIG_LEVEL and cur >= TRIG_LEVEL, compared signed on TRIG_CH.
    - Falling trigger: prev >= TRIG_LEVEL and cur < TRIG_LEVEL.
    - Free-run: trigger on the first stored sample in ARM.
    - prev is the previous stored sample. It is invalid after entering PRE until the first stored sample.
    - On trigger: latch start = (wp - PRE) mod DEPTH into the write-bank start register, pulse TRIG_SEEN, and go to POST. The triggering sample counts as post-trigger sample 0.
  - POST: write DEPTH-PRE samples total, including the triggering sample, then go to DONE.
  - DONE: no writes. On a registered FRAME_SYNC rising edge, toggle BANK. The display start register becomes the latched start. If RUN is high and mode != 3, go to PRE; otherwise go to IDLE.
- Read: physical address = (display start + RD_ADDR) mod DEPTH in bank BANK.
- RUN low in PRE, ARM or POST aborts to IDLE. BANK and the display start are unchanged; the partial capture is discarded.
- Single-shot mode: a new capture needs RUN to go low and then high again.

## Timing
- RESET: state IDLE; BANK=0; RD_DATA=0; ARMED=0; TRIG_SEEN=0; CAPT_DONE=0; wp, n, both start registers and the decimator all 0.
- RD_DATA is valid 1 CLK after RD_ADDR, for any read address.
- A write occurs in the same cycle as the stored SAMPLE_EN. The trigger decision uses that same sample, with no added latency.
- The FRAME_SYNC edge is detected 1 cycle after the input rises. BANK toggles on the following edge, 2 cycles after FRAME_SYNC rises.
- If the edge is detected in the same cycle that POST completes, the swap waits for the next FRAME_SYNC edge. A swap only happens when the edge is detected while already in DONE.
- SAMPLE_EN pulses arriving in DONE or IDLE still advance the decimator but are not stored.
- Reads and writes never target the same bank.

## Test plan
- Reset, then RD_ADDR=0..3 -> RD_DATA=0; BANK=0, all flags 0.
- Free-run, SCAL=0, RUN=1, ramp WAVE ch0 = k: one FRAME_SYNC after CAPT_DONE -> BANK=1 and RD_DATA ch0 at RD_ADDR i = i. Exactly DEPTH samples are stored.
- Rising mode, TRIG_LEVEL=100, ch0 = sawtooth 0..199: TRIG_SEEN when the sample with value 100 is stored. After the swap, RD_ADDR=PRE reads 100 and RD_ADDR=PRE-1 reads 99.
- SCAL=3 with a ramp on every strobe -> stored samples step by 4.
- Single-shot: one capture and swap, then stays IDLE while RUN stays high. A RUN low→high edge re-arms.
- RUN dropped mid-POST -> IDLE; BANK unchanged; the displayed data is still the previous capture.

Source files
------------

// File: rtl/scope_capture_buffer.sv
// Triggered multi-channel capture buffer with a two-bank ping-pong memory.
// One bank is written by the capture FSM while the other is scanned out by the display.
module scope_capture_buffer #(
  parameter int CH    = 2,
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  parameter int PRE   = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int TW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SAMPLE_EN,
  input  logic [CH*W-1:0]     WAVE,
  input  logic [2:0]          SCAL,
  input  logic                RUN,
  input  logic [1:0]          TRIG_MODE,
  input  logic [TW-1:0]       TRIG_CH,
  input  logic [W-1:0]        TRIG_LEVEL,
  input  logic                FRAME_SYNC,
  input  logic [AW-1:0]       RD_ADDR,
  output logic [CH*W-1:0]     RD_DATA,
  output logic                BANK,
  output logic                ARMED,
  output logic                TRIG_SEEN,
  output logic                CAPT_DONE
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARM, S_POST, S_DONE} state_t;

  localparam logic [AW:0] PRE_LAST  = (PRE > 0) ? (AW+1)'(PRE - 1) : '0;
  localparam logic [AW:0] POST_LAST = (AW+1)'(DEPTH - PRE - 1);

  logic [CH*W-1:0] mem [2*DEPTH];

  state_t              state;
  logic [AW-1:0]       wp, start_w, disp_start;
  logic [AW:0]         n;
  logic [2:0]          dcnt, scal_q, lim;
  logic                strobe, run_q, fs_q, fs_det, disp_vld;
  logic                prev_vld, rise, fall, trig, capturing, go;
  logic signed [W-1:0] cur, prev, lvl;

  // The period length is sampled at the start of each decimation period.
  assign lim    = (dcnt == 3'd0) ? SCAL : scal_q;
  assign strobe = SAMPLE_EN && (dcnt == 3'd0);

  always_comb begin
    cur = '0;
    for (int c = 0; c < CH; c++)
      if (TRIG_CH == TW'(c)) cur = WAVE[c*W +: W];
  end

  assign lvl  = TRIG_LEVEL;
  assign rise = prev_vld && (prev < lvl) && (cur >= lvl);
  assign fall = prev_vld && (prev >= lvl) && (cur < lvl);

  always_comb begin
    case (TRIG_MODE)
      2'd0:    trig = 1'b1;
      2'd2:    trig = fall;
      default: trig = rise;
    endcase
  end

  assign capturing = (state == S_PRE) || (state == S_ARM) || (state == S_POST);
  assign go        = (TRIG_MODE == 2'd3) ? (RUN && !run_q) : RUN;
  assign ARMED     = (state == S_ARM);
  assign CAPT_DONE = (state == S_DONE);

  always_ff @(posedge CLK) begin
    if (strobe && RUN && capturing) mem[{~BANK, wp}] <= WAVE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      wp         <= '0;
      n          <= '0;
      start_w    <= '0;
      disp_start <= '0;
      disp_vld   <= 1'b0;
      dcnt       <= '0;
      scal_q     <= '0;
      run_q      <= 1'b0;
      fs_q       <= 1'b0;
      fs_det     <= 1'b0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      BANK       <= 1'b0;
      TRIG_SEEN  <= 1'b0;
    end else begin
      TRIG_SEEN <= 1'b0;
      run_q     <= RUN;
      fs_q      <= FRAME_SYNC;
      fs_det    <= FRAME_SYNC && !fs_q;
      if (SAMPLE_EN) begin
        if (dcnt == 3'd0) scal_q <= SCAL;
        dcnt <= (dcnt == lim) ? 3'd0 : dcnt + 3'd1;
      end
      case (state)
        S_IDLE: if (go) begin
          wp       <= '0;
          n        <= '0;
          prev_vld <= 1'b0;
          state    <= (PRE == 0) ? S_ARM : S_PRE;
        end
        S_PRE, S_ARM, S_POST: begin
          if (!RUN) state <= S_IDLE;
          else if (strobe) begin
            wp       <= wp + 1'b1;
            prev     <= cur;
            prev_vld <= 1'b1;
            n        <= n + 1'b1;
            if (state == S_PRE) begin
              if (n == PRE_LAST) state <= S_ARM;
            end else if (state == S_ARM) begin
              if (trig) begin
                start_w   <= wp - AW'(PRE);
                TRIG_SEEN <= 1'b1;
                n         <= (AW+1)'(1);
                state     <= (DEPTH - PRE == 1) ? S_DONE : S_POST;
              end
            end else if (n == POST_LAST) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: if (fs_det) begin
          BANK       <= ~BANK;
          disp_start <= start_w;
          disp_vld   <= 1'b1;
          if (RUN && TRIG_MODE != 2'd3) begin
            wp       <= '0;
            n        <= '0;
            prev_vld <= 1'b0;
            state    <= (PRE == 0) ? S_ARM : S_PRE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Until the first swap the display bank holds no capture, so it reads as zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) RD_DATA <= '0;
    else       RD_DATA <= disp_vld ? mem[{BANK, disp_start + RD_ADDR}] : '0;
  end
endmodule
